// File: rtl/clock_pkg.sv
// Shared clock-adjust types: FSM state encoding, one-hot field selects and
// the month-length helper also used by the day counter.
package clock_pkg;

    localparam int unsigned FIELD_W = 6;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MON_W   = 4;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        ADJ_HOUR = 3'd1,
        ADJ_MIN  = 3'd2,
        ADJ_SEC  = 3'd3,
        ADJ_DAY  = 3'd4,
        ADJ_MON  = 3'd5,
        ADJ_YEAR = 3'd6,
        FIX_DAY  = 3'd7
    } state_t;

    localparam logic [FIELD_W-1:0] FLD_NONE = 6'b000000;
    localparam logic [FIELD_W-1:0] FLD_HOUR = 6'b000001;
    localparam logic [FIELD_W-1:0] FLD_MIN  = 6'b000010;
    localparam logic [FIELD_W-1:0] FLD_SEC  = 6'b000100;
    localparam logic [FIELD_W-1:0] FLD_DAY  = 6'b001000;
    localparam logic [FIELD_W-1:0] FLD_MON  = 6'b010000;
    localparam logic [FIELD_W-1:0] FLD_YEAR = 6'b100000;

    function automatic logic [DAY_W-1:0] max_day(input logic [MON_W-1:0] month,
                                                 input logic             leap);
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
            4'd2:                    max_day = leap ? 5'd29 : 5'd28;
            default:                 max_day = 5'd31;
        endcase
    endfunction

    // Successor state on a mode press.
    function automatic state_t next_mode(input state_t s);
        case (s)
            RUN:      next_mode = ADJ_HOUR;
            ADJ_HOUR: next_mode = ADJ_MIN;
            ADJ_MIN:  next_mode = ADJ_SEC;
            ADJ_SEC:  next_mode = ADJ_DAY;
            ADJ_DAY:  next_mode = ADJ_MON;
            ADJ_MON:  next_mode = ADJ_YEAR;
            ADJ_YEAR: next_mode = FIX_DAY;
            default:  next_mode = RUN;
        endcase
    endfunction

    function automatic logic [FIELD_W-1:0] field_of(input state_t s);
        case (s)
            ADJ_HOUR: field_of = FLD_HOUR;
            ADJ_MIN:  field_of = FLD_MIN;
            ADJ_SEC:  field_of = FLD_SEC;
            ADJ_DAY:  field_of = FLD_DAY;
            ADJ_MON:  field_of = FLD_MON;
            ADJ_YEAR: field_of = FLD_YEAR;
            default:  field_of = FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer, rising-edge detect and hold-to-repeat.
// Repeat is active only when ADJ_AUTOREPEAT_EN is defined and RPT_EN is set.
module btn_sync_edge #(
    parameter int unsigned REPEAT_DLY = 2,
    parameter bit          RPT_EN     = 1'b1
) (
    input  logic clk_1Hz,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic edge_c,
    output logic rpt_c
);

`ifdef ADJ_AUTOREPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    // REPEAT_DLY must be at least 1.
    localparam int unsigned HOLD_W = $clog2(REPEAT_DLY + 1);

    logic              meta;
    logic              level_d;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            meta    <= btn;
            level   <= meta;
            level_d <= level;
        end
    end

    // Cycles the synchronized level has been high, saturating at REPEAT_DLY.
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!level) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_W'(REPEAT_DLY)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign edge_c = level & ~level_d;
    assign rpt_c  = RPT_ON && RPT_EN && level && (hold_cnt == HOLD_W'(REPEAT_DLY));

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Time/date adjust controller: MODE steps through the field-select states,
// UP/DOWN become one-cycle pulses, and the day is clamped on exit.
// Optional hold-to-repeat on UP/DOWN is enabled by defining ADJ_AUTOREPEAT_EN.
module clock_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 30,
    parameter int unsigned REPEAT_DLY = 2
) (
    input  logic               clk_1Hz,
    input  logic               rst_n,
    input  logic               btn_mode,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [DAY_W-1:0]   day_bin,
    input  logic [MON_W-1:0]   month_bin,
    input  logic               leap_year,
    output logic               adjust,
    output logic               count_en,
    output logic [FIELD_W-1:0] field_sel,
    output logic               up_pulse,
    output logic               down_pulse,
    output logic               day_load,
    output logic [DAY_W-1:0]   day_load_val
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [IDLE_W-1:0]  idle_cnt;

    logic mode_edge, up_edge, down_edge;
    logic up_level, down_level;
    logic up_rpt, down_rpt;
    logic mode_level_unused, mode_rpt_unused;

    logic               up_fire_c, down_fire_c;
    logic               timeout_c, go_fix_c, clamp_c;
    state_t             mode_next_c;
    logic [DAY_W-1:0]   max_day_c;

    btn_sync_edge #(.REPEAT_DLY(REPEAT_DLY), .RPT_EN(1'b0)) u_mode (
        .clk_1Hz (clk_1Hz),
        .rst_n   (rst_n),
        .btn     (btn_mode),
        .level   (mode_level_unused),
        .edge_c  (mode_edge),
        .rpt_c   (mode_rpt_unused)
    );

    btn_sync_edge #(.REPEAT_DLY(REPEAT_DLY), .RPT_EN(1'b1)) u_up (
        .clk_1Hz (clk_1Hz),
        .rst_n   (rst_n),
        .btn     (btn_up),
        .level   (up_level),
        .edge_c  (up_edge),
        .rpt_c   (up_rpt)
    );

    btn_sync_edge #(.REPEAT_DLY(REPEAT_DLY), .RPT_EN(1'b1)) u_down (
        .clk_1Hz (clk_1Hz),
        .rst_n   (rst_n),
        .btn     (btn_down),
        .level   (down_level),
        .edge_c  (down_edge),
        .rpt_c   (down_rpt)
    );

    // Simultaneous up and down requests cancel; a repeat is suppressed while the other button is held.
    logic up_req_c, down_req_c;
    assign up_req_c    = up_edge   | (up_rpt   & ~down_level);
    assign down_req_c  = down_edge | (down_rpt & ~up_level);
    assign up_fire_c   = up_req_c   & ~down_req_c;
    assign down_fire_c = down_req_c & ~up_req_c;

    assign mode_next_c = next_mode(state);
    assign timeout_c   = (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign go_fix_c    = mode_edge ? (mode_next_c == FIX_DAY)
                                   : (~up_fire_c & ~down_fire_c & timeout_c);
    assign max_day_c   = max_day(month_bin, leap_year);
    assign clamp_c     = (day_bin > max_day_c);

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            adjust       <= 1'b0;
            count_en     <= 1'b1;
            field_sel    <= FLD_NONE;
            up_pulse     <= 1'b0;
            down_pulse   <= 1'b0;
            day_load     <= 1'b0;
            day_load_val <= DAY_W'(1);
            idle_cnt     <= '0;
        end else begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            day_load   <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_edge) begin
                        state     <= ADJ_HOUR;
                        adjust    <= 1'b1;
                        count_en  <= 1'b0;
                        field_sel <= FLD_HOUR;
                        idle_cnt  <= '0;
                    end
                end
                FIX_DAY: begin
                    state     <= RUN;
                    adjust    <= 1'b0;
                    count_en  <= 1'b1;
                    field_sel <= FLD_NONE;
                    idle_cnt  <= '0;
                end
                default: begin
                    if (go_fix_c) begin
                        // Leaving adjust: clamp the day to the current month's length.
                        state     <= FIX_DAY;
                        field_sel <= FLD_NONE;
                        idle_cnt  <= '0;
                        day_load  <= clamp_c;
                        if (clamp_c) begin
                            day_load_val <= max_day_c;
                        end
                    end else if (mode_edge) begin
                        state     <= mode_next_c;
                        field_sel <= field_of(mode_next_c);
                        idle_cnt  <= '0;
                    end else if (up_fire_c || down_fire_c) begin
                        up_pulse   <= up_fire_c;
                        down_pulse <= down_fire_c;
                        idle_cnt   <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
